border_cropper: RTL and testbench

Strips a P-wide border from a raster-streamed (N+2P)×(N+2P) feature frame and emits the N×N interior with a valid/ready handshake. It is the inverse of the padding stage: it sits after padded-domain processing (e.g. conv/pool output that retained its halo) and returns the stream to the unpadded N×N size the next layer expects. Frames stream back-to-back with no idle cycles required between them.

---
 rtl/cnn_stream_pkg.sv | 21 ++
 rtl/stream_skid_buffer.sv | 70 +++++++
 rtl/border_cropper.sv | 126 ++++++++++++
 tb/tb_border_cropper.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// rtl/cnn_stream_pkg.sv - shared frame-geometry helpers and FSM state constants for the padding/cropping stages
package cnn_stream_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_TOP    = 2'd1;
    localparam state_t ST_BODY   = 2'd2;
    localparam state_t ST_BOTTOM = 2'd3;

    // Side length of the padded frame.
    function automatic int padded_side(input int n, input int p);
        return n + 2 * p;
    endfunction

    // Width of the row/column counters; one spare code keeps W itself representable.
    function automatic int side_cnt_width(input int n, input int p);
        return $clog2(n + 2 * p + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - two-entry skid buffer with registered push_ready
module stream_skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    // push_valid already carries the upstream handshake; it never arrives while full.
    assign push = push_valid;
    assign pop  = (count_q != 2'd0) && pop_ready;

    // Next-state: write at wr_ptr, read at rd_ptr, ready drops only when both slots will be full.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != 2'd2);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Held low while reset is asserted so nothing is taken during reset.
    assign push_ready = ready_q & ~reset;
    assign pop_valid  = (count_q != 2'd0);
    assign pop_data   = mem_q[rd_ptr_q];

endmodule

// File: rtl/border_cropper.sv
// rtl/border_cropper.sv - strips a P-wide border from a streamed frame; BORDER_CHECK_EN adds border_err
module border_cropper
    import cnn_stream_pkg::*;
#(
    parameter int N          = 4,
    parameter int P          = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  last_out,
    output logic                  frame_done
`ifdef BORDER_CHECK_EN
    ,
    output logic                  border_err
`endif
);
    localparam int W  = padded_side(N, P);
    localparam int CW = side_cnt_width(N, P);
    localparam logic [CW-1:0] EDGE_IDX     = CW'(W - 1);
    localparam logic [CW-1:0] LAST_INT_IDX = CW'(N + P - 1);

    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   row_q, row_d;
    state_t          state_q, state_d;
    logic            frame_done_q, frame_done_d;
    logic            accept, col_end, row_end, interior, last_beat;
    logic [DATA_WIDTH:0] out_word;

    assign accept    = valid_in && ready_in;
    assign col_end   = (col_q == EDGE_IDX);
    assign row_end   = (row_q == EDGE_IDX);
    assign interior  = (int'(row_q) >= P) && (int'(row_q) < N + P) &&
                       (int'(col_q) >= P) && (int'(col_q) < N + P);
    assign last_beat = (row_q == LAST_INT_IDX) && (col_q == LAST_INT_IDX);

    // Raster position and frame-region tracking, advanced only by accepted beats.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        frame_done_d = accept && row_end && col_end;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // Region of the next beat; a frame-closing beat returns to IDLE, and the
            // next frame's first beat re-enters TOP/BODY directly from there.
            if (row_end && col_end) begin
                state_d = ST_IDLE;
            end else if (int'(row_d) < P) begin
                state_d = ST_TOP;
            end else if (int'(row_d) < N + P) begin
                state_d = ST_BODY;
            end else begin
                state_d = ST_BOTTOM;
            end
        end
    end

    // Position, region and frame_done registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

    // Only interior beats enter the buffer; border beats are consumed and dropped.
    stream_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (accept && interior),
        .push_ready (ready_in),
        .push_data  ({last_beat, data_in}),
        .pop_valid  (valid_out),
        .pop_ready  (ready_out),
        .pop_data   (out_word)
    );

    assign {last_out, data_out} = out_word;

`ifdef BORDER_CHECK_EN
    logic border_err_q, border_err_d;

    // Sticky flag for any non-zero value seen in the border region.
    always_comb begin
        border_err_d = border_err_q;
        if (accept && !interior && (data_in != '0)) begin
            border_err_d = 1'b1;
        end
    end

    // border_err register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            border_err_q <= 1'b0;
        end else begin
            border_err_q <= border_err_d;
        end
    end

    assign border_err = border_err_q;
`endif

endmodule

// File: tb/tb_border_cropper.sv
// tb/tb_border_cropper.sv - self-checking bench for border_cropper (N=4,P=1 and N=3,P=0)
`timescale 1ns/1ps
module tb_border_cropper;
    localparam int N  = 4;
    localparam int P  = 1;
    localparam int DW = 8;
    localparam int W  = N + 2 * P;
    localparam int N0 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          valid_in = 1'b0, ready_in, valid_out, ready_out = 1'b1, last_out, frame_done;
    logic [DW-1:0] data_in = '0, data_out;
    logic          valid_in0 = 1'b0, ready_in0, valid_out0, ready_out0 = 1'b1, last_out0, frame_done0;
    logic [DW-1:0] data_in0 = '0, data_out0;
`ifdef BORDER_CHECK_EN
    logic border_err, border_err0;
`endif

    border_cropper #(.N(N), .P(P), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .last_out(last_out),
        .frame_done(frame_done)
`ifdef BORDER_CHECK_EN
        , .border_err(border_err)
`endif
    );

    border_cropper #(.N(N0), .P(0), .DATA_WIDTH(DW)) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in0), .ready_in(ready_in0), .data_in(data_in0),
        .valid_out(valid_out0), .ready_out(ready_out0), .data_out(data_out0), .last_out(last_out0),
        .frame_done(frame_done0)
`ifdef BORDER_CHECK_EN
        , .border_err(border_err0)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Observation logs for the main DUT.
    int got_v[$];
    bit got_l[$];
    int got_c[$];
    int acc_c[$];
    int done_c[$];
    int fin_c[$];
    int pos = 0;
    int occ = 0;
    int rdy_bad = 0;
    int got0_v[$];
    bit got0_l[$];
    int exp_v[$];
    bit exp_l[$];

    always @(negedge clk) begin
        if (reset) begin
            pos = 0;
            occ = 0;
        end else begin
            if (ready_in !== (occ != 2)) rdy_bad++;
            if (valid_out && ready_out) begin
                got_v.push_back(int'(data_out));
                got_l.push_back(last_out);
                got_c.push_back(cyc);
                occ--;
            end
            if (frame_done) done_c.push_back(cyc);
            if (valid_in && ready_in) begin
                if (pos / W >= P && pos / W < N + P && pos % W >= P && pos % W < N + P) begin
                    occ++;
                    acc_c.push_back(cyc);
                end
                if (pos == W * W - 1) begin
                    fin_c.push_back(cyc);
                    pos = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && valid_out0 && ready_out0) begin
            got0_v.push_back(int'(data_out0));
            got0_l.push_back(last_out0);
        end
    end

    task automatic clear_logs();
        got_v.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
        done_c.delete(); fin_c.delete(); exp_v.delete(); exp_l.delete();
        got0_v.delete(); got0_l.delete();
        rdy_bad = 0;
    endtask

    // Reference: the interior of an (n+2p)^2 row-major frame, last flag on its final element.
    task automatic model_frame(input int vals[$], input int n, input int p);
        int w = n + 2 * p;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                exp_v.push_back(vals[(r + p) * w + (c + p)]);
                exp_l.push_back(r == n - 1 && c == n - 1);
            end
        end
    endtask

    task automatic do_reset();
        valid_in = 1'b0; valid_in0 = 1'b0; ready_out = 1'b1; ready_out0 = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        valid_in = 1'b0;
        ready_out = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // rmode: 0 ready_out high, 1 toggle with a 5-cycle stall, 2 random.
    task automatic send(input int vals[$], input int rmode, input bit gaps, output int used);
        int i = 0;
        int k = 0;
        while (i < vals.size() && k < 4000) begin
            valid_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in  = DW'(vals[i]);
            case (rmode)
                0:       ready_out = 1'b1;
                1:       ready_out = (k >= 20 && k < 25) ? 1'b0 : ((k % 2) == 0);
                default: ready_out = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk);
            if (valid_in && ready_in) i++;
            @(posedge clk);
            #1;
            k++;
        end
        valid_in = 1'b0;
        data_in  = '0;
        used = k;
        total++;
        if (i != vals.size()) begin
            bad++;
            $display("FAIL send_timeout: accepted=%0d required=%0d", i, vals.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset_ready_in: got=%b want=0", ready_in); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got=%b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out: got=%0d want=0", data_out); end
        total++; if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last_out: got=%b want=0", last_out); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got=%b want=0", frame_done); end
`ifdef BORDER_CHECK_EN
        total++; if (border_err !== 1'b0) begin bad++; $display("FAIL reset_border_err: got=%b want=0", border_err); end
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL post_reset_ready_in: got=%b want=1", ready_in); end
        total++; if (ready_in0 !== 1'b1) begin bad++; $display("FAIL post_reset_ready_in0: got=%b want=1", ready_in0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int vals[$];
        int used;
        clear_logs();
        for (int v = 1; v <= W * W; v++) vals.push_back(v);
        model_frame(vals, N, P);
        send(vals, 0, 1'b0, used);
        drain();
        total++; if (got_v.size() != 16) begin bad++; $display("FAIL basic_count: got=%0d want=16", got_v.size()); end
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
            total++;
            if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                bad++; $display("FAIL basic_beat%0d: got=%0d/%b want=%0d/%b", i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
            end
            total++;
            if (got_c[i] !== acc_c[i] + 1) begin
                bad++; $display("FAIL basic_latency%0d: got=%0d want=%0d", i, got_c[i] - acc_c[i], 1);
            end
        end
        total++;
        if (done_c.size() != 1 || fin_c.size() != 1 || done_c[0] !== fin_c[0] + 1) begin
            bad++; $display("FAIL basic_frame_done: pulses=%0d want=1 one cycle after final beat", done_c.size());
        end
    endtask

    task automatic test_stall();
        int vals[$];
        int used;
        clear_logs();
        for (int v = 1; v <= W * W; v++) vals.push_back(v);
        model_frame(vals, N, P);
        send(vals, 1, 1'b0, used);
        drain();
        total++; if (got_v.size() != 16) begin bad++; $display("FAIL stall_count: got=%0d want=16", got_v.size()); end
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
            total++;
            if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                bad++; $display("FAIL stall_beat%0d: got=%0d/%b want=%0d/%b", i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
            end
        end
        total++; if (rdy_bad !== 0) begin bad++; $display("FAIL stall_ready_in: bad_cycles=%0d want=0", rdy_bad); end
    endtask

    task automatic test_passthrough();
        int k = 0;
        int i = 0;
        clear_logs();
        while (i < N0 * N0 && k < 200) begin
            valid_in0 = 1'b1;
            data_in0  = DW'(i + 1);
            @(negedge clk);
            if (valid_in0 && ready_in0) i++;
            @(posedge clk);
            #1;
            k++;
        end
        valid_in0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (got0_v.size() != N0 * N0) begin bad++; $display("FAIL p0_count: got=%0d want=%0d", got0_v.size(), N0 * N0); end
        for (int j = 0; j < got0_v.size(); j++) begin
            total++;
            if (got0_v[j] !== j + 1 || got0_l[j] !== (j == N0 * N0 - 1)) begin
                bad++; $display("FAIL p0_beat%0d: got=%0d/%b want=%0d/%b", j, got0_v[j], got0_l[j], j + 1, (j == N0 * N0 - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int a[$];
        int b[$];
        int vals[$];
        int used;
        clear_logs();
        for (int v = 1; v <= W * W; v++) begin a.push_back(v); b.push_back(v + 100); end
        vals = {a, b};
        model_frame(a, N, P);
        model_frame(b, N, P);
        send(vals, 0, 1'b0, used);
        drain();
        total++; if (used != 2 * W * W) begin bad++; $display("FAIL b2b_cycles: got=%0d want=%0d", used, 2 * W * W); end
        total++; if (got_v.size() != 32) begin bad++; $display("FAIL b2b_count: got=%0d want=32", got_v.size()); end
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
            total++;
            if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                bad++; $display("FAIL b2b_beat%0d: got=%0d/%b want=%0d/%b", i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
            end
        end
        total++;
        if (done_c.size() != 2 || done_c[1] - done_c[0] != W * W) begin
            bad++; $display("FAIL b2b_frame_done: pulses=%0d want=2 spaced %0d", done_c.size(), W * W);
        end
    endtask

    task automatic test_midframe_reset();
        int part[$];
        int vals[$];
        int used;
        clear_logs();
        for (int v = 1; v <= 20; v++) part.push_back(v);
        send(part, 0, 1'b0, used);
        do_reset();
        clear_logs();
        for (int v = 1; v <= W * W; v++) vals.push_back(v);
        model_frame(vals, N, P);
        send(vals, 0, 1'b0, used);
        drain();
        total++; if (got_v.size() != 16) begin bad++; $display("FAIL mrst_count: got=%0d want=16", got_v.size()); end
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
            total++;
            if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                bad++; $display("FAIL mrst_beat%0d: got=%0d/%b want=%0d/%b", i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random();
        int vals[$];
        int fr[$];
        int used;
        clear_logs();
        for (int f = 0; f < 3; f++) begin
            fr.delete();
            for (int v = 0; v < W * W; v++) fr.push_back(int'($urandom_range(0, 255)));
            model_frame(fr, N, P);
            vals = {vals, fr};
        end
        send(vals, 2, 1'b1, used);
        drain();
        total++; if (got_v.size() != exp_v.size()) begin bad++; $display("FAIL rand_count: got=%0d want=%0d", got_v.size(), exp_v.size()); end
        for (int i = 0; i < got_v.size() && i < exp_v.size(); i++) begin
            total++;
            if (got_v[i] !== exp_v[i] || got_l[i] !== exp_l[i]) begin
                bad++; $display("FAIL rand_beat%0d: got=%0d/%b want=%0d/%b", i, got_v[i], got_l[i], exp_v[i], exp_l[i]);
            end
        end
        total++; if (rdy_bad !== 0) begin bad++; $display("FAIL rand_ready_in: bad_cycles=%0d want=0", rdy_bad); end
        total++; if (done_c.size() != 3) begin bad++; $display("FAIL rand_frame_done: got=%0d want=3", done_c.size()); end
    endtask

`ifdef BORDER_CHECK_EN
    task automatic test_border_err();
        int clean[$];
        int dirty[$];
        int used;
        do_reset();
        clear_logs();
        for (int v = 0; v < W * W; v++) begin
            if (v / W >= P && v / W < N + P && v % W >= P && v % W < N + P) clean.push_back(v + 1);
            else clean.push_back(0);
        end
        send(clean, 0, 1'b0, used);
        drain();
        total++; if (border_err !== 1'b0) begin bad++; $display("FAIL berr_clean: got=%b want=0", border_err); end
        dirty = clean;
        dirty[0] = 5;
        send(dirty, 0, 1'b0, used);
        total++; if (border_err !== 1'b1) begin bad++; $display("FAIL berr_set: got=%b want=1", border_err); end
        send(clean, 0, 1'b0, used);
        drain();
        total++; if (border_err !== 1'b1) begin bad++; $display("FAIL berr_sticky: got=%b want=1", border_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_passthrough();
        test_back_to_back();
        test_midframe_reset();
        test_random();
`ifdef BORDER_CHECK_EN
        test_border_err();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
